// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one ALU between NUM_REQ requesters, one operation in flight.
// Optional feature macro ALU_ARB_ERR_BYPASS_EN: requests with INP_VALID=2'b00 are answered with ERR, never issued.
module alu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int STD_LAT = 1,
    parameter int MUL_LAT = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         REQ_VALID,
    output logic [NUM_REQ-1:0]         REQ_READY,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_OPA,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_OPB,
    input  logic [NUM_REQ-1:0]         REQ_CIN,
    input  logic [NUM_REQ-1:0]         REQ_MODE,
    input  logic [NUM_REQ*4-1:0]       REQ_CMD,
    input  logic [NUM_REQ*2-1:0]       REQ_INP_VALID,
    output logic                       ALU_CE,
    output logic [1:0]                 ALU_INP_VALID,
    output logic [WIDTH-1:0]           ALU_OPA,
    output logic [WIDTH-1:0]           ALU_OPB,
    output logic                       ALU_CIN,
    output logic                       ALU_MODE,
    output logic [3:0]                 ALU_CMD,
    input  logic [2*WIDTH-1:0]         ALU_RES,
    input  logic                       ALU_COUT,
    input  logic                       ALU_OFLOW,
    input  logic                       ALU_G,
    input  logic                       ALU_E,
    input  logic                       ALU_L,
    input  logic                       ALU_ERR,
    output logic                       RSP_VALID,
    input  logic                       RSP_READY,
    output logic [$clog2(NUM_REQ)-1:0] RSP_ID,
    output logic [2*WIDTH-1:0]         RSP_RES,
    output logic [5:0]                 RSP_FLAGS
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int MAX_LAT = (MUL_LAT > STD_LAT) ? MUL_LAT : STD_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               cin_q, cin_d;
    logic               mode_q, mode_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [1:0]         iv_q, iv_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [5:0]         flags_q, flags_d;

    logic               srch_hit_s;
    logic [ID_W-1:0]    srch_id_s;
    logic [ID_W-1:0]    idx_s;
    logic               accept_s;
    logic               bypass_s;
    logic               is_mul_s;
    logic [1:0]         req_iv_s;
    int                 idx_v;

    // Round-robin search: walk offsets high to low so the lowest offset from rr_ptr wins.
    always_comb begin
        srch_hit_s = 1'b0;
        srch_id_s  = '0;
        idx_v      = 0;
        idx_s      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_v = int'(rr_ptr_q) + k;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end else begin
                idx_v = idx_v;
            end
            idx_s = idx_v[ID_W-1:0];
            if (REQ_VALID[idx_s]) begin
                srch_hit_s = 1'b1;
                srch_id_s  = idx_s;
            end else begin
                srch_hit_s = srch_hit_s;
            end
        end
    end

    assign accept_s = (state_q == S_IDLE) && srch_hit_s && !RST;
    assign req_iv_s = REQ_INP_VALID[int'(srch_id_s)*2 +: 2];
    assign is_mul_s = mode_q && ((cmd_q == 4'd9) || (cmd_q == 4'd10));

`ifdef ALU_ARB_ERR_BYPASS_EN
    assign bypass_s = (req_iv_s == 2'b00);
`else
    assign bypass_s = 1'b0;
`endif

    // Accept strobe to the granted requester only.
    always_comb begin
        REQ_READY = '0;
        if (accept_s) begin
            REQ_READY[srch_id_s] = 1'b1;
        end else begin
            REQ_READY = '0;
        end
    end

    // Next-state logic for the FSM, latched request and captured response.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        cin_d    = cin_q;
        mode_d   = mode_q;
        cmd_d    = cmd_q;
        iv_d     = iv_q;
        res_d    = res_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    gnt_d = srch_id_s;
                    if (bypass_s) begin
                        res_d   = '0;
                        flags_d = 6'b000001;
                        state_d = S_RESP;
                    end else begin
                        opa_d   = REQ_OPA[int'(srch_id_s)*WIDTH +: WIDTH];
                        opb_d   = REQ_OPB[int'(srch_id_s)*WIDTH +: WIDTH];
                        cin_d   = REQ_CIN[srch_id_s];
                        mode_d  = REQ_MODE[srch_id_s];
                        cmd_d   = REQ_CMD[int'(srch_id_s)*4 +: 4];
                        iv_d    = req_iv_s;
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = is_mul_s ? CNT_W'(MUL_LAT) : CNT_W'(STD_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = ALU_RES;
                    flags_d = {ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR};
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    rr_ptr_d = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cin_q    <= 1'b0;
            mode_q   <= 1'b0;
            cmd_q    <= 4'd0;
            iv_q     <= 2'b00;
            res_q    <= '0;
            flags_q  <= 6'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cin_q    <= cin_d;
            mode_q   <= mode_d;
            cmd_q    <= cmd_d;
            iv_q     <= iv_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
        end
    end

    // ALU operand registers hold their last values while CE is low.
    assign ALU_CE        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign ALU_INP_VALID = ALU_CE ? iv_q : 2'b00;
    assign ALU_OPA       = opa_q;
    assign ALU_OPB       = opb_q;
    assign ALU_CIN       = cin_q;
    assign ALU_MODE      = mode_q;
    assign ALU_CMD       = cmd_q;

    assign RSP_VALID = (state_q == S_RESP);
    assign RSP_ID    = gnt_q;
    assign RSP_RES   = res_q;
    assign RSP_FLAGS = flags_q;

endmodule
